// File: rtl/wave_scheduler.sv
// Per-SIMD wave scheduler: allocates context slots to dispatched waves and round-robin issues them.
// Optional SCHED_QUANTUM_EN keeps a wave selected for QUANTUM completed instructions before rotating.
module wave_scheduler #(
    parameter int WAVES_PER_SIMD = 5,
    parameter int WAVE_ID_WIDTH  = 16,
    parameter int QUANTUM        = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wave_req_valid,
    input  logic [WAVE_ID_WIDTH-1:0]              wave_req_id,
    output logic                                  wave_req_ready,
    input  logic                                  instr_done,
    input  logic                                  wave_exit,
    output logic                                  DISPATCH_NEW_WAVE,
    output logic                                  UPDATE_PC,
    output logic [$clog2(WAVES_PER_SIMD)-1:0]     active_context,
    output logic                                  active_valid,
    output logic [WAVE_ID_WIDTH-1:0]              active_wave_id,
    output logic                                  wave_retired_valid,
    output logic [WAVE_ID_WIDTH-1:0]              wave_retired_id,
    output logic [$clog2(WAVES_PER_SIMD+1)-1:0]   waves_resident
);
    localparam int CTX_W = $clog2(WAVES_PER_SIMD);
    localparam int CNT_W = $clog2(WAVES_PER_SIMD + 1);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_SELECT, S_ISSUE} state_t;

    state_t                    r_state;
    logic [WAVES_PER_SIMD-1:0] r_resident;
    logic [WAVE_ID_WIDTH-1:0]  r_ids [WAVES_PER_SIMD];
    logic [CTX_W-1:0]          r_last;
    logic [CTX_W-1:0]          r_ctx;
    logic                      r_ready;
    logic                      r_disp;
    logic                      r_upd;
    logic                      r_av;
    logic [WAVE_ID_WIDTH-1:0]  r_awid;
    logic                      r_rv;
    logic [WAVE_ID_WIDTH-1:0]  r_rid;
    logic [CNT_W-1:0]          r_count;

`ifdef SCHED_QUANTUM_EN
    localparam int QC_W = $clog2(QUANTUM + 1);
    logic [QC_W-1:0] r_qcnt;
    logic            r_hold;
`else
    logic w_unused_quantum;
    assign w_unused_quantum = (QUANTUM > 0);
`endif

    logic             w_accept;
    logic [CTX_W-1:0] w_free_slot;
    logic             w_rr_found;
    logic [CTX_W-1:0] w_rr_slot;

    // r_ready is only ever set in IDLE/SELECT with a free slot, so accept implies a slot exists
    assign w_accept = wave_req_valid && r_ready;

    always_comb begin
        w_free_slot = '0;
        for (int i = WAVES_PER_SIMD - 1; i >= 0; i--)
            if (!r_resident[i]) w_free_slot = CTX_W'(i);
    end

    // Descending offset so the nearest slot after r_last wins
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_slot  = '0;
        for (int i = WAVES_PER_SIMD; i >= 1; i--) begin
            if (r_resident[CTX_W'((int'(r_last) + i) % WAVES_PER_SIMD)]) begin
                w_rr_found = 1'b1;
                w_rr_slot  = CTX_W'((int'(r_last) + i) % WAVES_PER_SIMD);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_resident <= '0;
            for (int i = 0; i < WAVES_PER_SIMD; i++) r_ids[i] <= '0;
            r_last     <= CTX_W'(WAVES_PER_SIMD - 1);
            r_ctx      <= '0;
            r_ready    <= 1'b0;
            r_disp     <= 1'b0;
            r_upd      <= 1'b0;
            r_av       <= 1'b0;
            r_awid     <= '0;
            r_rv       <= 1'b0;
            r_rid      <= '0;
            r_count    <= '0;
`ifdef SCHED_QUANTUM_EN
            r_qcnt     <= '0;
            r_hold     <= 1'b0;
`endif
        end else begin
            r_disp <= 1'b0;
            r_upd  <= 1'b0;
            r_rv   <= 1'b0;
            if ((r_state == S_IDLE || r_state == S_SELECT) && w_accept) begin
                r_state                 <= S_DISPATCH;
                r_ctx                   <= w_free_slot;
                r_disp                  <= 1'b1;
                r_resident[w_free_slot] <= 1'b1;
                r_ids[w_free_slot]      <= wave_req_id;
                r_awid                  <= wave_req_id;
                r_count                 <= r_count + CNT_W'(1);
                r_ready                 <= 1'b0;
`ifdef SCHED_QUANTUM_EN
                r_qcnt                  <= '0;
                r_hold                  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: r_ready <= 1'b1;
                    S_DISPATCH: begin
                        r_state <= S_SELECT;
                        r_ready <= ~&r_resident;
                    end
                    S_SELECT: begin
`ifdef SCHED_QUANTUM_EN
                        if (r_hold) begin
                            r_state <= S_ISSUE;
                            r_av    <= 1'b1;
                            r_ready <= 1'b0;
                            r_hold  <= 1'b0;
                        end else
`endif
                        if (w_rr_found) begin
                            r_state <= S_ISSUE;
                            r_ctx   <= w_rr_slot;
                            r_last  <= w_rr_slot;
                            r_awid  <= r_ids[w_rr_slot];
                            r_av    <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        if (instr_done) begin
                            r_state <= S_SELECT;
                            r_av    <= 1'b0;
                            if (wave_exit) begin
                                r_rv              <= 1'b1;
                                r_rid             <= r_ids[r_ctx];
                                r_resident[r_ctx] <= 1'b0;
                                r_count           <= r_count - CNT_W'(1);
                                r_ready           <= 1'b1;
`ifdef SCHED_QUANTUM_EN
                                r_qcnt            <= '0;
`endif
                            end else begin
                                r_upd   <= 1'b1;
                                r_ready <= ~&r_resident;
`ifdef SCHED_QUANTUM_EN
                                if (r_qcnt == QC_W'(QUANTUM - 1)) begin
                                    r_qcnt <= '0;
                                end else begin
                                    r_qcnt <= r_qcnt + QC_W'(1);
                                    r_hold <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign wave_req_ready     = r_ready;
    assign DISPATCH_NEW_WAVE  = r_disp;
    assign UPDATE_PC          = r_upd;
    assign active_context     = r_ctx;
    assign active_valid       = r_av;
    assign active_wave_id     = r_awid;
    assign wave_retired_valid = r_rv;
    assign wave_retired_id    = r_rid;
    assign waves_resident     = r_count;
endmodule

// File: tb/tb_wave_scheduler.sv
// Cycle-by-cycle vector table for wave_scheduler plus a hand-written back-to-back fill sequence.
module tb_wave_scheduler;
    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wave_req_valid;
    logic [15:0] wave_req_id;
    logic        wave_req_ready;
    logic        instr_done;
    logic        wave_exit;
    logic        DISPATCH_NEW_WAVE;
    logic        UPDATE_PC;
    logic [2:0]  active_context;
    logic        active_valid;
    logic [15:0] active_wave_id;
    logic        wave_retired_valid;
    logic [15:0] wave_retired_id;
    logic [2:0]  waves_resident;

    wave_scheduler #(.WAVES_PER_SIMD(5), .WAVE_ID_WIDTH(16), .QUANTUM(Q)) dut (
        .clk(clk), .rst(rst),
        .wave_req_valid(wave_req_valid), .wave_req_id(wave_req_id), .wave_req_ready(wave_req_ready),
        .instr_done(instr_done), .wave_exit(wave_exit),
        .DISPATCH_NEW_WAVE(DISPATCH_NEW_WAVE), .UPDATE_PC(UPDATE_PC),
        .active_context(active_context), .active_valid(active_valid), .active_wave_id(active_wave_id),
        .wave_retired_valid(wave_retired_valid), .wave_retired_id(wave_retired_id),
        .waves_resident(waves_resident)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v;
        logic [15:0] id;
        logic        d, e;
        logic        rdy, disp, upd;
        logic [2:0]  ctx;
        logic        av, rv;
        logic [15:0] rid;
        logic [2:0]  res;
        logic [15:0] awid;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic row(input logic r, input logic v, input logic [15:0] id, input logic d, input logic e,
                       input logic rdy, input logic disp, input logic upd, input logic [2:0] ctx,
                       input logic av, input logic rv, input logic [15:0] rid, input logic [2:0] res,
                       input logic [15:0] awid);
        vec_t t;
        t.rst = r; t.v = v; t.id = id; t.d = d; t.e = e;
        t.rdy = rdy; t.disp = disp; t.upd = upd; t.ctx = ctx; t.av = av; t.rv = rv;
        t.rid = rid; t.res = res; t.awid = awid;
        tbl.push_back(t);
    endtask

    task automatic rst_rows();
        row(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic offer(input logic [15:0] id, input logic [2:0] slot);
        bit got = 0;
        wave_req_valid = 1'b1;
        wave_req_id    = id;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (DISPATCH_NEW_WAVE) begin got = 1; break; end
        end
        n_vec++;
        if (!got || active_context !== slot || active_wave_id !== id) begin
            n_err++;
            $display("FAIL fill id %h: got dispatched=%0d ctx=%0d wid=%h, want ctx=%0d wid=%h",
                     id, got, active_context, active_wave_id, slot, id);
        end
    endtask

    initial begin
        logic [42:0] act, exp;
        int c;
        // reset, then one wave issuing three instructions
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 1, 16'h7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h7);
        row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h7);
        for (int k = 0; k < 3; k++) begin
            row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h7);
            row(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 16'h7);
        end
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h7);
        rst_rows();  // reset lands mid-ISSUE with instr_done high
        // fill all five slots, sixth offer waits for a retire
        row(0, 1, 16'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h1);
        row(0, 1, 16'h2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h1);
        row(0, 1, 16'h2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 16'h2);
        row(0, 1, 16'h3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 16'h2);
        row(0, 1, 16'h3, 0, 0, 0, 1, 0, 2, 0, 0, 0, 3, 16'h3);
        row(0, 1, 16'h4, 0, 0, 1, 0, 0, 2, 0, 0, 0, 3, 16'h3);
        row(0, 1, 16'h4, 0, 0, 0, 1, 0, 3, 0, 0, 0, 4, 16'h4);
        row(0, 1, 16'h5, 0, 0, 1, 0, 0, 3, 0, 0, 0, 4, 16'h4);
        row(0, 1, 16'h5, 0, 0, 0, 1, 0, 4, 0, 0, 0, 5, 16'h5);
        row(0, 1, 16'h6, 0, 0, 0, 0, 0, 4, 0, 0, 0, 5, 16'h5);
        row(0, 1, 16'h6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 16'h1);
        row(0, 1, 16'h6, 1, 1, 1, 0, 0, 0, 0, 1, 16'h1, 4, 16'h1);
        row(0, 1, 16'h6, 0, 0, 0, 1, 0, 0, 0, 0, 16'h1, 5, 16'h6);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1, 5, 16'h6);
        row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h1, 5, 16'h2);
        row(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 16'h1, 5, 16'h2);
        rst_rows();
        // three waves, eight instructions
        row(0, 1, 16'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h10);
        row(0, 1, 16'h11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h10);
        row(0, 1, 16'h11, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 16'h11);
        row(0, 1, 16'h12, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 16'h11);
        row(0, 1, 16'h12, 0, 0, 0, 1, 0, 2, 0, 0, 0, 3, 16'h12);
        row(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 3, 16'h12);
        for (int k = 0; k < 8; k++) begin
`ifdef SCHED_QUANTUM_EN
            c = (k / Q) % 3;
`else
            c = k % 3;
`endif
            row(0, 0, 0, 0, 0, 0, 0, 0, 3'(c), 1, 0, 0, 3, 16'h10 + 16'(c));
            row(0, 0, 0, 1, 0, 1, 0, 1, 3'(c), 0, 0, 0, 3, 16'h10 + 16'(c));
        end
        rst_rows();
        // wave 0x42 in slot 1 exits; slot 1 is reused
        row(0, 1, 16'h41, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h41);
        row(0, 1, 16'h42, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h41);
        row(0, 1, 16'h42, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2, 16'h42);
        row(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 16'h42);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 16'h41);
        row(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2, 16'h41);
        row(0, 1, 16'h43, 0, 0, 0, 1, 0, 2, 0, 0, 0, 3, 16'h43);
        row(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 3, 16'h43);
        row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 16'h42);
        row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 16'h42);
        row(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 3, 16'h42);
        row(0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 16'h42, 2, 16'h42);
        row(0, 1, 16'h44, 0, 0, 0, 1, 0, 1, 0, 0, 16'h42, 3, 16'h44);
        row(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h42, 3, 16'h44);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; wave_req_valid = tbl[i].v; wave_req_id = tbl[i].id;
            instr_done = tbl[i].d; wave_exit = tbl[i].e;
            @(posedge clk); #1;
            act = {wave_req_ready, DISPATCH_NEW_WAVE, UPDATE_PC, active_context, active_valid,
                   wave_retired_valid, wave_retired_id, waves_resident, active_wave_id};
            exp = {tbl[i].rdy, tbl[i].disp, tbl[i].upd, tbl[i].ctx, tbl[i].av,
                   tbl[i].rv, tbl[i].rid, tbl[i].res, tbl[i].awid};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL vec%0d: got rdy/disp/upd/ctx/av/rv/rid/res/wid %h, want %h", i, act, exp);
            end
        end

        // back-to-back offers with the bounded wait, ending full
        rst = 1'b1; wave_req_valid = 1'b0; instr_done = 1'b0; wave_exit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 0; s < 5; s++) offer(16'h100 + 16'(s), 3'(s));
        wave_req_id = 16'h105;
        @(posedge clk); #1;
        n_vec++;
        if (wave_req_ready !== 1'b0 || waves_resident !== 3'd5) begin
            n_err++;
            $display("FAIL full: got ready=%0d res=%0d, want ready=0 res=5", wave_req_ready, waves_resident);
        end
        @(posedge clk); #1;
        n_vec++;
        if (active_valid !== 1'b1 || active_context !== 3'd0 || DISPATCH_NEW_WAVE !== 1'b0) begin
            n_err++;
            $display("FAIL full-issue: got av=%0d ctx=%0d disp=%0d, want av=1 ctx=0 disp=0",
                     active_valid, active_context, DISPATCH_NEW_WAVE);
        end
        wave_req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wave_scheduler.md
Name: wave_scheduler

Overview:
Per-SIMD wave scheduler that drives the per-wave PC context bank: it issues DISPATCH_NEW_WAVE, UPDATE_PC and active_context.
- Accepts new wavefronts from the workgroup dispatcher over a valid/ready handshake.
- Allocates each accepted wave a free context slot.
- Round-robin interleaves the resident waves, one instruction at a time.
- Retires a wave's slot when that wave exits.

Parameters:
WAVES_PER_SIMD, 5, number of context slots; must be >= 2
WAVE_ID_WIDTH, 16, width of the global wave identifier
QUANTUM, 4, instructions issued per wave before rotating (used only with SCHED_QUANTUM_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wave_req_valid  in  1  dispatcher offers a new wave
wave_req_id  in  WAVE_ID_WIDTH  global id of the offered wave
wave_req_ready  out  1  free slot available; offer accepted when valid&&ready
instr_done  in  1  active wave's current instruction completed
wave_exit  in  1  qualifies instr_done: completed instruction was the wave's end instruction
DISPATCH_NEW_WAVE  out  1  one-cycle pulse; PC bank zeroes the context on active_context
UPDATE_PC  out  1  one-cycle pulse; PC bank increments the context on active_context
active_context  out  $clog2(WAVES_PER_SIMD)  slot currently selected
active_valid  out  1  active_context holds a resident wave in ISSUE
active_wave_id  out  WAVE_ID_WIDTH  id of the wave in active_context
wave_retired_valid  out  1  one-cycle pulse on wave exit
wave_retired_id  out  WAVE_ID_WIDTH  id of the retired wave
waves_resident  out  $clog2(WAVES_PER_SIMD+1)  count of occupied slots

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, resident bitmap=0, last_context=WAVES_PER_SIMD-1 (first pick is slot 0). All outputs are 0; wave_req_ready rises the cycle after rst deasserts.
- Reset mid-operation: everything clears at that edge, with no pulse outputs.
- State storage: registered outputs. Per-slot state is a resident bit and a wave id.
- wave_req_ready = (state is IDLE or SELECT) and at least one resident bit is clear.
- Allocation: an accepted wave takes the lowest-index free slot.
- IDLE: no resident waves.
  - On accept -> DISPATCH.
- DISPATCH (1 cycle):
  - active_context = allocated slot; DISPATCH_NEW_WAVE=1.
  - Set the resident bit and store the id; waves_resident+1.
  - -> SELECT.
- SELECT (1 cycle):
  - If a request is accepted, go -> DISPATCH. Dispatch has priority over issue.
  - Otherwise pick the next resident slot round-robin, searching from last_context+1 mod WAVES_PER_SIMD.
  - Load active_context with that slot, update last_context, and go -> ISSUE.
  - If no slot is resident, go -> IDLE.
- ISSUE:
  - active_valid=1.
  - The PC bank presents that context's pc_out from the second ISSUE cycle onward.
  - Wait indefinitely for instr_done; wave_exit is ignored unless instr_done=1.
- instr_done=1 and wave_exit=0:
  - Next cycle UPDATE_PC=1 with active_context unchanged.
  - Then go -> SELECT. Without the macro, every instruction rotates.
- instr_done=1 and wave_exit=1:
  - No UPDATE_PC.
  - Next cycle wave_retired_valid=1 with the stored id, the resident bit clears, and waves_resident-1.
  - Then go -> SELECT. The freed slot is allocatable from that SELECT.
- Exclusivity: UPDATE_PC and DISPATCH_NEW_WAVE are never asserted together. active_context is stable throughout each pulse.
- Full condition: all slots resident -> ready=0. A pending valid is held by the dispatcher and not accepted.

Optional Feature:
SCHED_QUANTUM_EN
- Defined: a per-wave issue counter keeps the same context for QUANTUM consecutive completed instructions (UPDATE_PC each) before rotating.
  - Exit, or a newly accepted dispatch in SELECT, resets the counter.
  - Between instructions the state passes through SELECT, but the same slot is reselected.
- Undefined: rotate after every instruction; the QUANTUM parameter is unused.

Test Plan:
1. Hold rst 2 cycles, release -> all outputs 0 during reset; wave_req_ready=1 one cycle later; waves_resident=0.
2. Offer id 0x0007 for one cycle -> DISPATCH_NEW_WAVE pulse with active_context=0, waves_resident=1. Then 3 instr_done -> 3 UPDATE_PC pulses, all context 0.
3. Offer ids 1..6 back-to-back -> slots 0..4 filled; ready=0 after the 5th; id 6 stays pending until a retire, then lands in the freed slot.
4. Three waves resident, instr_done every ISSUE (macro off) -> UPDATE_PC contexts 0,1,2,0,1,2.
5. Wave 0x0042 in slot 1 asserts instr_done+wave_exit -> no UPDATE_PC; wave_retired_valid with id 0x0042; resident count-1; next request allocated slot 1.
6. SCHED_QUANTUM_EN, QUANTUM=4, two waves -> UPDATE_PC contexts 0,0,0,0,1,1,1,1; rst asserted mid-ISSUE -> outputs 0 next cycle, no pulses.
